// File: rtl/cv32e40p_obi_mem_responder.sv
// rtl/cv32e40p_obi_mem_responder.sv - OBI slave with word memory, fixed response latency and outstanding limit
// Grants combinationally, answers strictly in order through a RESP_LATENCY-deep delay line.
module cv32e40p_obi_mem_responder #(
   parameter int MEM_WORDS       = 1024,
   parameter int RESP_LATENCY    = 1,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   input  logic        gnt_stall_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   logic [31:0]   r_mem   [MEM_WORDS];
   logic          r_vld   [RESP_LATENCY];
   logic [31:0]   r_rdata [RESP_LATENCY];
   logic          r_err   [RESP_LATENCY];
   logic [CW-1:0] r_outstanding;

   logic          w_accept;
   logic          w_in_range;
   logic          w_unused_addr;
   logic [AW-1:0] w_idx;

   // Byte offset bits play no part: lanes come from be_i alone.
   assign w_unused_addr = ^addr_i[1:0];
   assign w_in_range    = (addr_i[31:AW+2] == '0);
   assign w_idx         = addr_i[AW+1:2];

   assign gnt_o    = req_i & ~gnt_stall_i & (r_outstanding < MAX_CNT) & ~rst_i;
   assign w_accept = req_i & gnt_o;

   // Memory is deliberately outside reset so contents survive it.
   always_ff @(posedge clk_i) begin
      if (w_accept && we_i && w_in_range) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < RESP_LATENCY; i++) begin
            r_vld[i]   <= 1'b0;
            r_rdata[i] <= 32'h0;
            r_err[i]   <= 1'b0;
         end
         r_outstanding <= '0;
      end else begin
         r_vld[0]   <= w_accept;
         r_err[0]   <= w_accept & ~w_in_range;
         r_rdata[0] <= (w_accept && !we_i && w_in_range) ? r_mem[w_idx] : 32'h0;
         for (int i = 1; i < RESP_LATENCY; i++) begin
            r_vld[i]   <= r_vld[i-1];
            r_rdata[i] <= r_rdata[i-1];
            r_err[i]   <= r_err[i-1];
         end
         if (w_accept && !rvalid_o) begin
            r_outstanding <= r_outstanding + CW'(1);
         end else if (!w_accept && rvalid_o) begin
            r_outstanding <= r_outstanding - CW'(1);
         end
      end
   end

   assign rvalid_o = r_vld[RESP_LATENCY-1];
   assign rdata_o  = r_rdata[RESP_LATENCY-1];
   assign err_o    = r_err[RESP_LATENCY-1];
endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// tb/tb_cv32e40p_obi_mem_responder.sv - directed and random checks of the OBI responder against a queue model
module tb_cv32e40p_obi_mem_responder;
   localparam int MEM_WORDS = 1024;
   localparam int LAT       = 3;
   localparam int MAX_OUT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall = 1'b0;
   logic        gnt_o, rvalid_o, err_o;
   logic [31:0] rdata_o;

   cv32e40p_obi_mem_responder #(
      .MEM_WORDS(MEM_WORDS), .RESP_LATENCY(LAT), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o), .addr_i(addr),
      .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_stall_i(stall),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   resp_t       mq[$];
   logic [31:0] mmem [MEM_WORDS];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          gnt_log[$];
   int          rv_cyc_log[$];
   logic [31:0] rv_data_log[$];
   logic        rv_err_log[$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Model: pending responses are a queue with due cycles; outstanding is its length.
   always @(negedge clk) begin
      logic        exp_gnt, exp_rv, exp_err, acc, in_rng;
      logic [31:0] exp_rd, rd;
      int          idx;
      exp_rv  = (mq.size() > 0) && (mq[0].due == cyc);
      exp_rd  = exp_rv ? mq[0].rdata : 32'h0;
      exp_err = exp_rv ? mq[0].err : 1'b0;
      exp_gnt = req && !stall && (mq.size() < MAX_OUT) && !rst;
      if (cyc >= 1) begin
         chk("gnt", {31'b0, gnt_o}, {31'b0, exp_gnt});
         chk("rvalid", {31'b0, rvalid_o}, {31'b0, exp_rv});
         chk("rdata", rdata_o, exp_rd);
         chk("err", {31'b0, err_o}, {31'b0, exp_err});
      end
      acc = req && exp_gnt;
      if (acc) gnt_log.push_back(cyc);
      if (exp_rv) begin
         rv_cyc_log.push_back(cyc);
         rv_data_log.push_back(exp_rd);
         rv_err_log.push_back(exp_err);
      end
      if (rst) begin
         mq.delete();
      end else begin
         if (exp_rv) void'(mq.pop_front());
         if (acc) begin
            in_rng = addr < 32'(4 * MEM_WORDS);
            idx    = in_rng ? int'(addr >> 2) : 0;
            rd     = (!we && in_rng) ? mmem[idx] : 32'h0;
            if (we && in_rng) begin
               for (int k = 0; k < 4; k++) begin
                  if (be[k]) mmem[idx][8*k +: 8] = wdata[8*k +: 8];
               end
            end
            mq.push_back('{cyc + LAT, rd, !in_rng});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      gnt_log.delete();
      rv_cyc_log.delete();
      rv_data_log.delete();
      rv_err_log.delete();
   endtask

   task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      logic g;
      int   n;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      g = 1'b0;
      n = 0;
      while (!g && n < 50) begin
         @(negedge clk);
         g = gnt_o;
         @(posedge clk);
         #1;
         n++;
      end
      if (!g) chk("txn_timeout", 32'h0, 32'h1);
      req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && mq.size() != 0; i++) step();
      if (mq.size() != 0) chk("drain_timeout", 32'(mq.size()), 32'h0);
      step();
   endtask

   initial begin
      int          t0;
      logic        g;
      logic [31:0] ra;

      // Reset held with a pending request
      req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
      step();
      repeat (2) begin
         @(negedge clk);
         chk("rst_gnt", {31'b0, gnt_o}, 32'h0);
         chk("rst_rvalid", {31'b0, rvalid_o}, 32'h0);
         chk("rst_rdata", rdata_o, 32'h0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      req = 1'b0;
      step();

      for (int w = 0; w < 16; w++) txn(1'b1, 32'(w * 4), 4'hF, $urandom);
      drain();

      // Byte-enabled write merge
      clear_logs();
      txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      txn(1'b1, 32'h10, 4'h1, 32'h000000AA);
      txn(1'b0, 32'h10, 4'hF, 32'h0);
      drain();
      chk("be_count", 32'(rv_data_log.size()), 32'd3);
      chk("be_rdata", rv_data_log[2], 32'hDEADBEAA);
      chk("be_err", {31'b0, rv_err_log[2]}, 32'h0);
      chk("be_wr_rdata", rv_data_log[0], 32'h0);
      chk("be_latency", 32'(rv_cyc_log[2] - gnt_log[2]), 32'(LAT));

      // Back-to-back reads against the outstanding limit
      for (int w = 0; w < 4; w++) txn(1'b1, 32'h20 + 32'(w * 4), 4'hF, 32'(w + 1));
      drain();
      clear_logs();
      t0 = cyc;
      for (int w = 0; w < 4; w++) txn(1'b0, 32'h20 + 32'(w * 4), 4'hF, 32'h0);
      drain();
      chk("b2b_count", 32'(rv_data_log.size()), 32'd4);
      chk("b2b_gnt0", 32'(gnt_log[0] - t0), 32'd0);
      chk("b2b_gnt1", 32'(gnt_log[1] - t0), 32'd1);
      chk("b2b_gnt2", 32'(gnt_log[2] - t0), 32'd4);
      chk("b2b_gnt3", 32'(gnt_log[3] - t0), 32'd5);
      chk("b2b_rv0", 32'(rv_cyc_log[0] - t0), 32'd3);
      chk("b2b_rv1", 32'(rv_cyc_log[1] - t0), 32'd4);
      chk("b2b_rv2", 32'(rv_cyc_log[2] - t0), 32'd7);
      chk("b2b_rv3", 32'(rv_cyc_log[3] - t0), 32'd8);
      for (int i = 0; i < 4; i++) chk("b2b_data", rv_data_log[i], 32'(i + 1));

      // Grant stall
      clear_logs();
      stall = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h24; be = 4'hF;
      t0 = cyc;
      repeat (5) begin
         @(negedge clk);
         chk("stall_gnt", {31'b0, gnt_o}, 32'h0);
         @(posedge clk);
         #1;
      end
      stall = 1'b0;
      txn(1'b0, 32'h24, 4'hF, 32'h0);
      drain();
      chk("stall_gnt_cycle", 32'(gnt_log[0] - t0), 32'd5);
      chk("stall_resp_count", 32'(rv_data_log.size()), 32'd1);
      chk("stall_rdata", rv_data_log[0], 32'd2);

      // Out of range
      clear_logs();
      txn(1'b1, 32'h0, 4'hF, 32'h12345678);
      txn(1'b0, 32'h1000, 4'hF, 32'h0);
      txn(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
      txn(1'b0, 32'h0, 4'hF, 32'h0);
      drain();
      chk("oor_rd_err", {31'b0, rv_err_log[1]}, 32'h1);
      chk("oor_rd_data", rv_data_log[1], 32'h0);
      chk("oor_wr_err", {31'b0, rv_err_log[2]}, 32'h1);
      chk("oor_mem_kept", rv_data_log[3], 32'h12345678);

      // Reset with two reads in flight
      clear_logs();
      txn(1'b0, 32'h20, 4'hF, 32'h0);
      txn(1'b0, 32'h28, 4'hF, 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (6) step();
      chk("midrst_accepts", 32'(gnt_log.size()), 32'd2);
      chk("midrst_no_rvalid", 32'(rv_cyc_log.size()), 32'd0);
      txn(1'b0, 32'h0, 4'hF, 32'h0);
      drain();
      chk("midrst_after", rv_data_log[0], 32'h12345678);
      chk("midrst_after_count", 32'(rv_data_log.size()), 32'd1);

      // Random traffic honouring the hold-while-not-granted rule
      g = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         if (!(req && !g)) begin
            req   = ($urandom_range(0, 9) < 7);
            we    = $urandom_range(0, 1) == 1;
            be    = 4'($urandom);
            wdata = $urandom;
            case ($urandom_range(0, 9))
               8:       ra = 32'h1000 + 32'($urandom_range(0, 255));
               9:       ra = $urandom | 32'h8000_0000;
               default: ra = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            endcase
            addr = ra;
         end
         stall = ($urandom_range(0, 4) == 0);
         rst   = ($urandom_range(0, 99) == 0);
         @(negedge clk);
         g = gnt_o;
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      stall = 1'b0;
      req = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cv32e40p_obi_mem_responder.md
# cv32e40p_obi_mem_responder

Behavioural OBI responder that sits on the far side of the core's data (or instruction) memory interface and answers `req`/`gnt`/`rvalid` transactions from a word-organised memory. It gives the verification environment a cycle-accurate slave with:

- a programmable response latency;
- a bounded number of outstanding transactions;
- externally driven grant stalls;
- an error response for out-of-range addresses.

## Interface

Parameters:

- `MEM_WORDS`, 1024 — memory depth in 32-bit words; power of two, ≥ 4.
- `RESP_LATENCY`, 1 — cycles from grant to `rvalid_o`; ≥ 1.
- `MAX_OUTSTANDING`, 2 — maximum number of granted-but-unanswered transactions; ≥ 1.

Ports:

- `clk_i` in 1 — single clock, rising edge.
- `rst_i` in 1 — reset; synchronous, active-high.
- `req_i` in 1 — request from the initiator.
- `gnt_o` out 1 — grant; combinational.
- `addr_i` in 32 — byte address.
- `we_i` in 1 — 1 = write, 0 = read.
- `be_i` in 4 — byte enables.
- `wdata_i` in 32 — write data.
- `gnt_stall_i` in 1 — testbench backpressure; forces `gnt_o` low.
- `rvalid_o` out 1 — response valid, one cycle per transaction.
- `rdata_o` out 32 — read data; 0 for writes, errors, and when `rvalid_o` = 0.
- `err_o` out 1 — error flag, qualified by `rvalid_o`.

## Operation

Grant rule:

- `gnt_o = req_i & ~gnt_stall_i & (outstanding < MAX_OUTSTANDING) & ~rst_i`.
- A transaction is accepted on a cycle where `req_i & gnt_o` is true.
- The initiator must hold `addr_i`/`we_i`/`be_i`/`wdata_i` stable while `req_i` is high and `gnt_o` is low. The responder does not check this.

Addressing:

- Word index is `addr_i[1:0]` dropped, i.e. `addr_i >> 2`.
- Out of range means `addr_i >= 4*MEM_WORDS`.
- Byte offsets `addr_i[1:0]` are ignored; byte lanes are selected by `be_i` only.

Writes:

- Lane `k` of the memory word is updated on the accept edge when `be_i[k]` = 1.
- The response carries `rdata` = 0, `err` = 0.
- An out-of-range write updates nothing and responds with `err` = 1.

Reads:

- The full 32-bit word is sampled on the accept edge, regardless of `be_i`.
- An out-of-range read responds with `rdata` = 0, `err` = 1.

Response pipeline:

- Delay line of `RESP_LATENCY` stages, each holding {valid, rdata, err}.
- Stage 0 is loaded on accept; the last stage drives `rvalid_o`/`rdata_o`/`err_o`.
- Responses are strictly in order.
- Exactly one `rvalid_o` pulse per accepted transaction.

Outstanding counter:

- Width `$clog2(MAX_OUTSTANDING+1)`.
- +1 on accept, −1 when `rvalid_o` = 1; a simultaneous accept and `rvalid_o` leaves it unchanged.
- Never exceeds `MAX_OUTSTANDING`; `gnt_o` is low while it equals `MAX_OUTSTANDING`.

Ordering hazards:

- A read accepted in the cycle after a write to the same word returns the written data.
- The memory has a single port, so a read and a write are never accepted in the same cycle.

Reset:

- Applies on an edge with `rst_i` = 1.
- Clears every pipeline stage and the counter; in-flight responses are dropped, with no `rvalid_o` for them.
- Memory contents are not reset. A write accepted before the reset edge persists.
- `gnt_o` = 0 while `rst_i` = 1.

## Timing

Reset values:

- `rvalid_o` = 0, `rdata_o` = 0, `err_o` = 0, outstanding = 0.
- `gnt_o` = 0 during reset, then follows the combinational rule.

Latency:

- Accept at edge `t` gives `rvalid_o` = 1 in cycle `t + RESP_LATENCY`, i.e. visible after edge `t + RESP_LATENCY`.

Throughput:

- One accept per cycle when `MAX_OUTSTANDING ≥ RESP_LATENCY + 1`.
- Otherwise at most `MAX_OUTSTANDING` accepts per `RESP_LATENCY + 1` cycles.

Counter at the limit:

- When the counter is at the limit and `rvalid_o` = 1 in the same cycle, `gnt_o` stays low that cycle, because the counter is evaluated from the registered value.
- A grant resumes the next cycle.

`gnt_stall_i` timing:

- Acts combinationally in the same cycle.
- Deasserting it with `req_i` high grants in that same cycle.

## Test plan

- **Reset:** `rst_i` = 1 for 2 cycles with `req_i` = 1 → `gnt_o` = 0, `rvalid_o` = 0, `rdata_o` = 0 throughout.
- **Byte-enabled write then read:**
  - Sequence: write `0xDEADBEEF` to `0x10` with `be` = `0xF`, then write `0x000000AA` with `be` = `0x1`, then read `0x10`.
  - `RESP_LATENCY` = 1: read `rvalid_o` arrives 1 cycle after its grant with `rdata_o` = `0xDEADBEAA`, `err_o` = 0.
- **Back-to-back reads at full rate:**
  - Configuration: `RESP_LATENCY` = 3, `MAX_OUTSTANDING` = 2; 4 reads of preloaded words 1..4.
  - Grants in cycles 0, 1, 4, 5; `rvalid_o` in cycles 3, 4, 7, 8; data returned in order 1, 2, 3, 4.
- **Stall:**
  - Stimulus: `gnt_stall_i` = 1 for 5 cycles with `req_i` held.
  - `gnt_o` = 0 for those 5 cycles; grant occurs in the cycle stall drops; exactly one response.
- **Out of range:** with `MEM_WORDS` = 1024, read `0x1000` → `rvalid_o` = 1, `err_o` = 1, `rdata_o` = 0. A write to `0x1000` leaves memory unchanged.
- **Reset mid-flight:**
  - Stimulus: accept 2 reads with `RESP_LATENCY` = 3, then assert `rst_i` one cycle later.
  - No `rvalid_o` follows; counter = 0; a subsequent read completes normally.
